// File: rtl/ship_action_engine.sv
// ship_action_engine
// Authoritative per-team ship state. Each step pulse applies clamped
// acceleration, velocity and position updates, energy-priced actions
// (fire, shield, cloak), enemy hits and bullet flight. The cloak-held
// public position is exported for the opposing team. Per-ship vector
// ports are packed with ship i in slice [i*W +: W].
module ship_action_engine #(
  parameter int NUM_SHIPS    = 3,
  parameter int MAX_ACCEL    = 4,
  parameter int MAX_VEL      = 6,
  parameter int BOARD_HALF   = 32,
  parameter int MAX_ENERGY   = 80,
  parameter int RECHARGE     = 15,
  parameter int FIRE_COST    = 30,
  parameter int SHIELD_COST  = 25,
  parameter int CLOAK_COST   = 15,
  parameter int BULLET_SPEED = 9,
  parameter int BULLET_TIME  = 6,
  parameter int START_X      = -16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   step,
  input  logic [4*NUM_SHIPS-1:0] x_a,
  input  logic [4*NUM_SHIPS-1:0] y_a,
  input  logic [NUM_SHIPS-1:0]   attempt_fire,
  input  logic [NUM_SHIPS-1:0]   attempt_shield,
  input  logic [NUM_SHIPS-1:0]   attempt_cloak,
  input  logic [2*NUM_SHIPS-1:0] fire_dir,
  input  logic [NUM_SHIPS-1:0]   hit,
  output logic [8*NUM_SHIPS-1:0] x,
  output logic [8*NUM_SHIPS-1:0] y,
  output logic [8*NUM_SHIPS-1:0] vx,
  output logic [8*NUM_SHIPS-1:0] vy,
  output logic [8*NUM_SHIPS-1:0] energy,
  output logic [NUM_SHIPS-1:0]   destroyed,
  output logic [NUM_SHIPS-1:0]   shield_on,
  output logic [NUM_SHIPS-1:0]   cloak_on,
  output logic [NUM_SHIPS-1:0]   fired,
  output logic [NUM_SHIPS-1:0]   bullet_active,
  output logic [8*NUM_SHIPS-1:0] bullet_x,
  output logic [8*NUM_SHIPS-1:0] bullet_y,
  output logic [8*NUM_SHIPS-1:0] pub_x,
  output logic [8*NUM_SHIPS-1:0] pub_y,
  output logic                   step_done
);

  localparam int LIFE_W  = $clog2(BULLET_TIME + 1);
  localparam int START_Y = -16;
  localparam int Y_PITCH = 16;

  localparam logic signed [7:0] ACC_MAX  = 8'(MAX_ACCEL);
  localparam logic signed [7:0] ACC_MIN  = 8'(-MAX_ACCEL);
  localparam logic signed [8:0] VEL_MAX  = 9'(MAX_VEL);
  localparam logic signed [8:0] VEL_MIN  = 9'(-MAX_VEL);
  localparam logic signed [8:0] HALF_MAX = 9'(BOARD_HALF);
  localparam logic signed [8:0] HALF_MIN = 9'(-BOARD_HALF);
  localparam logic signed [8:0] BSPD     = 9'(BULLET_SPEED);
  localparam logic [8:0]        E_MAX    = 9'(MAX_ENERGY);
  localparam logic [8:0]        E_FIRE   = 9'(FIRE_COST);
  localparam logic [8:0]        E_SHIELD = 9'(SHIELD_COST);
  localparam logic [8:0]        E_CLOAK  = 9'(CLOAK_COST);
  localparam logic [8:0]        E_RECH   = 9'(RECHARGE);

  // Sign-extend an 8-bit coordinate/velocity to 9 bits for overflow-free sums.
  function automatic logic signed [8:0] sx9(input logic signed [7:0] v);
    return $signed({v[7], v});
  endfunction

  // Clamp a 4-bit requested acceleration to +/-MAX_ACCEL, widened to 8 bits.
  function automatic logic signed [7:0] clamp_accel(input logic signed [3:0] a);
    logic signed [7:0] a8;
    a8 = $signed({{4{a[3]}}, a});
    if (a8 > ACC_MAX)      return ACC_MAX;
    else if (a8 < ACC_MIN) return ACC_MIN;
    else                   return a8;
  endfunction

  // Saturate a 9-bit velocity sum to +/-MAX_VEL.
  function automatic logic signed [7:0] sat_vel(input logic signed [8:0] v);
    if (v > VEL_MAX)      return VEL_MAX[7:0];
    else if (v < VEL_MIN) return VEL_MIN[7:0];
    else                  return v[7:0];
  endfunction

  // True when a 9-bit coordinate lies beyond the board edge.
  function automatic logic off_board(input logic signed [8:0] p);
    return (p > HALF_MAX) || (p < HALF_MIN);
  endfunction

  // Clamp a 9-bit coordinate onto the board.
  function automatic logic signed [7:0] clamp_pos(input logic signed [8:0] p);
    if (p > HALF_MAX)      return HALF_MAX[7:0];
    else if (p < HALF_MIN) return HALF_MIN[7:0];
    else                   return p[7:0];
  endfunction

  logic signed [7:0]  x_r [NUM_SHIPS];
  logic signed [7:0]  y_r [NUM_SHIPS];
  logic signed [7:0]  vx_r [NUM_SHIPS];
  logic signed [7:0]  vy_r [NUM_SHIPS];
  logic [7:0]         energy_r [NUM_SHIPS];
  logic signed [7:0]  bx_r [NUM_SHIPS];
  logic signed [7:0]  by_r [NUM_SHIPS];
  logic signed [7:0]  pubx_r [NUM_SHIPS];
  logic signed [7:0]  puby_r [NUM_SHIPS];
  logic [LIFE_W-1:0]  life_r [NUM_SHIPS];
  logic [1:0]         bdir_r [NUM_SHIPS];
  logic [NUM_SHIPS-1:0] destroyed_r, shield_r, cloak_r, fired_r, bact_r;
  logic               step_done_r;

  logic signed [7:0]  x_s [NUM_SHIPS];
  logic signed [7:0]  y_s [NUM_SHIPS];
  logic signed [7:0]  vx_s [NUM_SHIPS];
  logic signed [7:0]  vy_s [NUM_SHIPS];
  logic [7:0]         energy_s [NUM_SHIPS];
  logic signed [7:0]  bx_s [NUM_SHIPS];
  logic signed [7:0]  by_s [NUM_SHIPS];
  logic signed [7:0]  pubx_s [NUM_SHIPS];
  logic signed [7:0]  puby_s [NUM_SHIPS];
  logic [LIFE_W-1:0]  life_s [NUM_SHIPS];
  logic [1:0]         bdir_s [NUM_SHIPS];
  logic [NUM_SHIPS-1:0] destroyed_s, shield_s, cloak_s, fired_s, bact_s;
  logic               step_done_s;

  // Next-state computation for every ship; all state holds when step is low.
  always_comb begin : next_state_comb
    logic signed [7:0] ax, ay, nvx, nvy;
    logic signed [8:0] vx9, vy9, px9, py9, bx9, by9;
    logic [8:0]        e9;
    logic [LIFE_W-1:0] life_n;
    logic              fire_g, shield_g, cloak_g, oob;
    step_done_s = step;
    destroyed_s = destroyed_r;
    shield_s    = shield_r;
    cloak_s     = cloak_r;
    fired_s     = fired_r;
    bact_s      = bact_r;
    for (int i = 0; i < NUM_SHIPS; i++) begin
      x_s[i]      = x_r[i];
      y_s[i]      = y_r[i];
      vx_s[i]     = vx_r[i];
      vy_s[i]     = vy_r[i];
      energy_s[i] = energy_r[i];
      bx_s[i]     = bx_r[i];
      by_s[i]     = by_r[i];
      pubx_s[i]   = pubx_r[i];
      puby_s[i]   = puby_r[i];
      life_s[i]   = life_r[i];
      bdir_s[i]   = bdir_r[i];
      ax       = clamp_accel($signed(x_a[i*4 +: 4]));
      ay       = clamp_accel($signed(y_a[i*4 +: 4]));
      vx9      = sx9(vx_r[i]) + sx9(ax);
      vy9      = sx9(vy_r[i]) + sx9(ay);
      nvx      = sat_vel(vx9);
      nvy      = sat_vel(vy9);
      px9      = sx9(x_r[i]) + sx9(nvx);
      py9      = sx9(y_r[i]) + sx9(nvy);
      oob      = off_board(px9) || off_board(py9);
      e9       = {1'b0, energy_r[i]};
      fire_g   = 1'b0;
      shield_g = 1'b0;
      cloak_g  = 1'b0;
      bx9      = sx9(bx_r[i]);
      by9      = sx9(by_r[i]);
      life_n   = life_r[i] - LIFE_W'(1);

      if (step) begin
        if (!destroyed_r[i]) begin
          // Actions are priced in fixed priority: fire, then shield, then cloak.
          fire_g   = attempt_fire[i] && (e9 >= E_FIRE) && !bact_r[i];
          e9       = fire_g ? (e9 - E_FIRE) : e9;
          shield_g = attempt_shield[i] && (e9 >= E_SHIELD);
          e9       = shield_g ? (e9 - E_SHIELD) : e9;
          cloak_g  = attempt_cloak[i] && (e9 >= E_CLOAK);
          e9       = cloak_g ? (e9 - E_CLOAK) : e9;
          e9       = e9 + E_RECH;
          e9       = (e9 > E_MAX) ? E_MAX : e9;

          vx_s[i]        = nvx;
          vy_s[i]        = nvy;
          x_s[i]         = clamp_pos(px9);
          y_s[i]         = clamp_pos(py9);
          energy_s[i]    = e9[7:0];
          // A shield only deflects hits; leaving the board is always fatal.
          destroyed_s[i] = oob || (hit[i] && !shield_g);
          pubx_s[i]      = cloak_g ? pubx_r[i] : clamp_pos(px9);
          puby_s[i]      = cloak_g ? puby_r[i] : clamp_pos(py9);
        end else begin
          vx_s[i]   = 8'sd0;
          vy_s[i]   = 8'sd0;
          pubx_s[i] = x_r[i];
          puby_s[i] = y_r[i];
        end
        shield_s[i] = shield_g;
        cloak_s[i]  = cloak_g;
        fired_s[i]  = fire_g;

        // Advance a bullet already in flight, expiring on life or board edge.
        if (bact_r[i]) begin
          case (bdir_r[i])
            2'd0:    bx9 = bx9 + BSPD;
            2'd1:    by9 = by9 - BSPD;
            2'd2:    bx9 = bx9 - BSPD;
            2'd3:    by9 = by9 + BSPD;
            default: bx9 = bx9;
          endcase
          bx_s[i]   = bx9[7:0];
          by_s[i]   = by9[7:0];
          life_s[i] = life_n;
          bact_s[i] = (life_n != LIFE_W'(0)) && !off_board(bx9) && !off_board(by9);
        end else begin
          bact_s[i] = 1'b0;
        end

        // A fresh bullet appears at the new ship position and does not move yet.
        if (fire_g) begin
          bact_s[i] = 1'b1;
          bx_s[i]   = x_s[i];
          by_s[i]   = y_s[i];
          life_s[i] = LIFE_W'(BULLET_TIME);
          bdir_s[i] = fire_dir[i*2 +: 2];
        end else begin
          bdir_s[i] = bdir_r[i];
        end
      end else begin
        step_done_s = 1'b0;
      end
    end
  end

  // State register with synchronous reset that overrides any coincident step.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SHIPS; i++) begin
        x_r[i]      <= 8'(START_X);
        y_r[i]      <= 8'(START_Y + Y_PITCH * i);
        vx_r[i]     <= 8'sd0;
        vy_r[i]     <= 8'sd0;
        energy_r[i] <= 8'(MAX_ENERGY);
        bx_r[i]     <= 8'sd0;
        by_r[i]     <= 8'sd0;
        pubx_r[i]   <= 8'(START_X);
        puby_r[i]   <= 8'(START_Y + Y_PITCH * i);
        life_r[i]   <= LIFE_W'(0);
        bdir_r[i]   <= 2'd0;
      end
      destroyed_r <= '0;
      shield_r    <= '0;
      cloak_r     <= '0;
      fired_r     <= '0;
      bact_r      <= '0;
      step_done_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SHIPS; i++) begin
        x_r[i]      <= x_s[i];
        y_r[i]      <= y_s[i];
        vx_r[i]     <= vx_s[i];
        vy_r[i]     <= vy_s[i];
        energy_r[i] <= energy_s[i];
        bx_r[i]     <= bx_s[i];
        by_r[i]     <= by_s[i];
        pubx_r[i]   <= pubx_s[i];
        puby_r[i]   <= puby_s[i];
        life_r[i]   <= life_s[i];
        bdir_r[i]   <= bdir_s[i];
      end
      destroyed_r <= destroyed_s;
      shield_r    <= shield_s;
      cloak_r     <= cloak_s;
      fired_r     <= fired_s;
      bact_r      <= bact_s;
      step_done_r <= step_done_s;
    end
  end

  for (genvar g = 0; g < NUM_SHIPS; g++) begin : g_pack
    assign x[g*8 +: 8]        = x_r[g];
    assign y[g*8 +: 8]        = y_r[g];
    assign vx[g*8 +: 8]       = vx_r[g];
    assign vy[g*8 +: 8]       = vy_r[g];
    assign energy[g*8 +: 8]   = energy_r[g];
    assign bullet_x[g*8 +: 8] = bx_r[g];
    assign bullet_y[g*8 +: 8] = by_r[g];
    assign pub_x[g*8 +: 8]    = pubx_r[g];
    assign pub_y[g*8 +: 8]    = puby_r[g];
  end

  assign destroyed     = destroyed_r;
  assign shield_on     = shield_r;
  assign cloak_on      = cloak_r;
  assign fired         = fired_r;
  assign bullet_active = bact_r;
  assign step_done     = step_done_r;

endmodule
